// File: rtl/reg_status_file_pkg.sv
// Shared sizing constants for the architectural register file and its read ports.
package reg_status_file_pkg;

    localparam int REG_ADDR_SIZE = 5;
    localparam int INST_SIZE     = 32;
    localparam int ROB_TAG_SIZE  = 5;
    localparam int REG_COUNT     = 32;

    localparam logic [INST_SIZE-1:0]     ZERO_WORD = '0;
    localparam logic [REG_ADDR_SIZE-1:0] ZERO_REG  = '0;
    localparam logic                     ONE_BIT   = 1'b1;

endpackage

// File: rtl/reg_read_port.sv
// Combinational source-operand lookup with same-cycle commit bypass.
module reg_read_port
    import reg_status_file_pkg::*;
#(
    parameter int NREG  = REG_COUNT,
    parameter int XLEN  = INST_SIZE,
    parameter int TAG_W = ROB_TAG_SIZE
) (
    input  logic [REG_ADDR_SIZE-1:0]        rs,
    input  logic [NREG-1:0]                 busy_q,
    input  logic [NREG-1:0][TAG_W-1:0]      tag_q,
    input  logic [NREG-1:0][XLEN-1:0]       val_q,
    input  logic                            commit_en,
    input  logic [REG_ADDR_SIZE-1:0]        commit_rd,
    input  logic [TAG_W-1:0]                commit_tag,
    input  logic [XLEN-1:0]                 commit_val,
    output logic                            busy,
    output logic [TAG_W-1:0]                tag,
    output logic [XLEN-1:0]                 val
);

    always_comb begin
        busy = 1'b0;
        tag  = '0;
        val  = '0;
        if (rs != ZERO_REG) begin
            busy = busy_q[rs];
            tag  = tag_q[rs];
            val  = val_q[rs];
            // The producer is retiring right now: hand its result straight through.
            if (busy_q[rs] && commit_en && (commit_rd == rs) && (tag_q[rs] == commit_tag)) begin
                busy = 1'b0;
                val  = commit_val;
            end
        end
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register busy bit and ROB tag, fed by ROB commit and issue rename.
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int NREG  = REG_COUNT,
    parameter int XLEN  = INST_SIZE,
    parameter int TAG_W = ROB_TAG_SIZE
) (
    input  logic                     clk_in,
    input  logic                     rstn_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     commit_en_in,
    input  logic [TAG_W-1:0]         commit_tag_in,
    input  logic [REG_ADDR_SIZE-1:0] commit_rd_in,
    input  logic [XLEN-1:0]          commit_val_in,
    input  logic                     rename_en_in,
    input  logic [REG_ADDR_SIZE-1:0] rename_rd_in,
    input  logic [TAG_W-1:0]         rename_tag_in,
    input  logic [REG_ADDR_SIZE-1:0] rs1_in,
    input  logic [REG_ADDR_SIZE-1:0] rs2_in,
    output logic                     rs1_busy_out,
    output logic                     rs2_busy_out,
    output logic [TAG_W-1:0]         rs1_tag_out,
    output logic [TAG_W-1:0]         rs2_tag_out,
    output logic [XLEN-1:0]          rs1_val_out,
    output logic [XLEN-1:0]          rs2_val_out
);

    logic [NREG-1:0]            busy_q;
    logic [NREG-1:0][TAG_W-1:0] tag_q;
    logic [NREG-1:0][XLEN-1:0]  val_q;

    logic commit_hit;
    logic rename_hit;

    assign commit_hit = commit_en_in && (commit_rd_in != ZERO_REG);
    assign rename_hit = rename_en_in && (rename_rd_in != ZERO_REG) && !clear_in;

    // Later assignments win: commit clears busy, rename re-arms it, flush clears everything.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            busy_q <= '0;
            tag_q  <= '0;
            val_q  <= '0;
        end else if (rdy_in) begin
            if (commit_hit) begin
                val_q[commit_rd_in] <= commit_val_in;
                if (busy_q[commit_rd_in] && (tag_q[commit_rd_in] == commit_tag_in))
                    busy_q[commit_rd_in] <= 1'b0;
            end
            if (rename_hit) begin
                busy_q[rename_rd_in] <= ONE_BIT;
                tag_q[rename_rd_in]  <= rename_tag_in;
            end
            if (clear_in)
                busy_q <= '0;
        end
    end

    reg_read_port #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W)) u_rs1_port (
        .rs         (rs1_in),
        .busy_q     (busy_q),
        .tag_q      (tag_q),
        .val_q      (val_q),
        .commit_en  (commit_en_in),
        .commit_rd  (commit_rd_in),
        .commit_tag (commit_tag_in),
        .commit_val (commit_val_in),
        .busy       (rs1_busy_out),
        .tag        (rs1_tag_out),
        .val        (rs1_val_out)
    );

    reg_read_port #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W)) u_rs2_port (
        .rs         (rs2_in),
        .busy_q     (busy_q),
        .tag_q      (tag_q),
        .val_q      (val_q),
        .commit_en  (commit_en_in),
        .commit_rd  (commit_rd_in),
        .commit_tag (commit_tag_in),
        .commit_val (commit_val_in),
        .busy       (rs2_busy_out),
        .tag        (rs2_tag_out),
        .val        (rs2_val_out)
    );

endmodule

// File: tb/tb_reg_status_file.sv
// Directed scoreboard bench for reg_status_file: expected read-port results are queued, then checked.
module tb_reg_status_file;

    logic        clk_in = 1'b0;
    logic        rstn_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        commit_en_in = 1'b0;
    logic [4:0]  commit_tag_in = '0;
    logic [4:0]  commit_rd_in = '0;
    logic [31:0] commit_val_in = '0;
    logic        rename_en_in = 1'b0;
    logic [4:0]  rename_rd_in = '0;
    logic [4:0]  rename_tag_in = '0;
    logic [4:0]  rs1_in = '0;
    logic [4:0]  rs2_in = '0;
    logic        rs1_busy_out, rs2_busy_out;
    logic [4:0]  rs1_tag_out, rs2_tag_out;
    logic [31:0] rs1_val_out, rs2_val_out;

    reg_status_file dut (
        .clk_in        (clk_in),
        .rstn_in       (rstn_in),
        .rdy_in        (rdy_in),
        .clear_in      (clear_in),
        .commit_en_in  (commit_en_in),
        .commit_tag_in (commit_tag_in),
        .commit_rd_in  (commit_rd_in),
        .commit_val_in (commit_val_in),
        .rename_en_in  (rename_en_in),
        .rename_rd_in  (rename_rd_in),
        .rename_tag_in (rename_tag_in),
        .rs1_in        (rs1_in),
        .rs2_in        (rs2_in),
        .rs1_busy_out  (rs1_busy_out),
        .rs2_busy_out  (rs2_busy_out),
        .rs1_tag_out   (rs1_tag_out),
        .rs2_tag_out   (rs2_tag_out),
        .rs1_val_out   (rs1_val_out),
        .rs2_val_out   (rs2_val_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       nm;
        bit          port2;
        logic [37:0] exp;
        logic [37:0] mask;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    localparam logic [37:0] M_ALL   = {38{1'b1}};
    localparam logic [37:0] M_NOTAG = {1'b1, 5'b0, 32'hFFFF_FFFF};
    localparam logic [37:0] M_NOVAL = {6'h3F, 32'h0};

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic expect_rd(input string nm, input bit port2, input logic [4:0] rs,
                             input logic b, input logic [4:0] t, input logic [31:0] v,
                             input logic [37:0] mask);
        sb_t e;
        e.nm = nm;
        e.port2 = port2;
        e.exp = {b, t, v};
        e.mask = mask;
        if (port2) rs2_in = rs;
        else       rs1_in = rs;
        sb_q.push_back(e);
    endtask

    task automatic compare();
        sb_t e;
        logic [37:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs = e.port2 ? {rs2_busy_out, rs2_tag_out, rs2_val_out}
                          : {rs1_busy_out, rs1_tag_out, rs1_val_out};
            n_cmp++;
            assert ((obs & e.mask) === (e.exp & e.mask)) else begin
                n_bad++;
                $error("FAIL %s: observed busy/tag/val=%h required=%h (mask %h)",
                       e.nm, obs, e.exp, e.mask);
            end
        end
    endtask

    initial begin
        // Asynchronous reset: outputs go to zero without a clock edge.
        #2 rstn_in = 1'b0;
        expect_rd("reset_x5", 0, 5'd5, 1'b0, 5'd0, 32'h0, M_ALL);
        expect_rd("reset_x0", 1, 5'd0, 1'b0, 5'd0, 32'h0, M_ALL);
        compare();
        tick(); tick();
        rstn_in = 1'b1;
        tick();
        expect_rd("post_reset_x5", 0, 5'd5, 1'b0, 5'd0, 32'h0, M_ALL);
        compare();

        // Rename x5 -> tag 3; same-cycle read still sees the old mapping.
        rename_en_in = 1; rename_rd_in = 5'd5; rename_tag_in = 5'd3;
        expect_rd("rename_same_cycle_x5", 0, 5'd5, 1'b0, 5'd0, 32'h0, M_ALL);
        compare();
        tick();
        rename_en_in = 0;
        expect_rd("renamed_x5", 0, 5'd5, 1'b1, 5'd3, 32'h0, M_ALL);
        compare();
        commit_en_in = 1; commit_tag_in = 5'd3; commit_rd_in = 5'd5; commit_val_in = 32'h1234;
        expect_rd("bypass_x5_p1", 0, 5'd5, 1'b0, 5'd0, 32'h1234, M_NOTAG);
        expect_rd("bypass_x5_p2", 1, 5'd5, 1'b0, 5'd0, 32'h1234, M_NOTAG);
        compare();
        tick();
        commit_en_in = 0;
        expect_rd("retired_x5", 0, 5'd5, 1'b0, 5'd0, 32'h1234, M_NOTAG);
        compare();

        // Stale commit: x7 renamed twice, older tag retires.
        rename_en_in = 1; rename_rd_in = 5'd7; rename_tag_in = 5'd2;
        tick();
        rename_tag_in = 5'd9;
        tick();
        rename_en_in = 0;
        commit_en_in = 1; commit_tag_in = 5'd2; commit_rd_in = 5'd7; commit_val_in = 32'hAA;
        expect_rd("stale_no_bypass_x7", 1, 5'd7, 1'b1, 5'd9, 32'h0, M_ALL);
        compare();
        tick();
        commit_en_in = 0;
        expect_rd("stale_kept_busy_x7", 0, 5'd7, 1'b1, 5'd9, 32'hAA, M_ALL);
        compare();

        // Same-cycle rename and commit on x8.
        rename_en_in = 1; rename_rd_in = 5'd8; rename_tag_in = 5'd4;
        tick();
        rename_tag_in = 5'd6;
        commit_en_in = 1; commit_tag_in = 5'd4; commit_rd_in = 5'd8; commit_val_in = 32'h5555;
        expect_rd("same_cycle_bypass_x8", 0, 5'd8, 1'b0, 5'd0, 32'h5555, M_NOTAG);
        compare();
        tick();
        rename_en_in = 0; commit_en_in = 0;
        expect_rd("rename_wins_x8", 0, 5'd8, 1'b1, 5'd6, 32'h5555, M_ALL);
        compare();

        // Flush with coincident link commit and discarded rename.
        rename_en_in = 1; rename_rd_in = 5'd3; rename_tag_in = 5'd10;
        tick();
        rename_rd_in = 5'd4; rename_tag_in = 5'd11;
        tick();
        rename_en_in = 0;
        expect_rd("busy_x3", 0, 5'd3, 1'b1, 5'd10, 32'h0, M_ALL);
        expect_rd("busy_x4", 1, 5'd4, 1'b1, 5'd11, 32'h0, M_ALL);
        compare();
        clear_in = 1;
        commit_en_in = 1; commit_tag_in = 5'd0; commit_rd_in = 5'd1; commit_val_in = 32'h10;
        rename_en_in = 1; rename_rd_in = 5'd9; rename_tag_in = 5'd12;
        tick();
        clear_in = 0; commit_en_in = 0; rename_en_in = 0;
        expect_rd("flush_x3", 0, 5'd3, 1'b0, 5'd0, 32'h0, M_NOTAG);
        expect_rd("flush_x4", 1, 5'd4, 1'b0, 5'd0, 32'h0, M_NOTAG);
        compare();
        expect_rd("flush_link_x1", 0, 5'd1, 1'b0, 5'd0, 32'h10, M_NOTAG);
        expect_rd("flush_drop_rename_x9", 1, 5'd9, 1'b0, 5'd0, 32'h0, M_ALL);
        compare();
        expect_rd("flush_x7", 0, 5'd7, 1'b0, 5'd0, 32'hAA, M_NOTAG);
        expect_rd("flush_x8", 1, 5'd8, 1'b0, 5'd0, 32'h5555, M_NOTAG);
        compare();

        // x0 ignores commit and rename.
        commit_en_in = 1; commit_tag_in = 5'd0; commit_rd_in = 5'd0; commit_val_in = 32'hFFFF;
        rename_en_in = 1; rename_rd_in = 5'd0; rename_tag_in = 5'd5;
        expect_rd("x0_during_write", 0, 5'd0, 1'b0, 5'd0, 32'h0, M_ALL);
        compare();
        tick();
        commit_en_in = 0; rename_en_in = 0;
        expect_rd("x0_after_write", 1, 5'd0, 1'b0, 5'd0, 32'h0, M_ALL);
        compare();

        // rdy_in low holds all state.
        rdy_in = 0;
        rename_en_in = 1; rename_rd_in = 5'd10; rename_tag_in = 5'd13;
        commit_en_in = 1; commit_tag_in = 5'd0; commit_rd_in = 5'd5; commit_val_in = 32'hBEEF;
        tick();
        rdy_in = 1; rename_en_in = 0; commit_en_in = 0;
        expect_rd("hold_no_rename_x10", 0, 5'd10, 1'b0, 5'd0, 32'h0, M_ALL);
        expect_rd("hold_no_commit_x5", 1, 5'd5, 1'b0, 5'd0, 32'h1234, M_NOTAG);
        compare();

        // Mid-operation reset wipes mappings and values.
        rename_en_in = 1; rename_rd_in = 5'd11; rename_tag_in = 5'd14;
        tick();
        rename_en_in = 0;
        expect_rd("pre_reset_busy_x11", 0, 5'd11, 1'b1, 5'd14, 32'h0, M_ALL);
        compare();
        #1 rstn_in = 1'b0;
        expect_rd("reset_clears_x11", 0, 5'd11, 1'b0, 5'd0, 32'h0, M_ALL);
        expect_rd("reset_clears_x5", 1, 5'd5, 1'b0, 5'd0, 32'h0, M_ALL);
        compare();
        tick();
        rstn_in = 1'b1;
        tick();
        expect_rd("after_reset_x8", 0, 5'd8, 1'b0, 5'd0, 32'h0, M_ALL);
        compare();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
